// File: rtl/tpu_uart_host.sv
// Host-side TPU UART command initiator: sends opcode + payload bytes, then gathers
// a fixed-length response with an inter-byte timeout. Optional counters: TPU_UART_HOST_STATS_EN.
module tpu_uart_host #(
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int TO_W           = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_opcode,
  input  logic [31:0] cmd_payload,
  input  logic [2:0]  cmd_payload_len,
  input  logic [2:0]  cmd_resp_len,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_timeout,
  output logic        busy
`ifdef TPU_UART_HOST_STATS_EN
  ,
  output logic [15:0] stat_cmds,
  output logic [7:0]  stat_timeouts,
  output logic [7:0]  stat_stray
`endif
);

  typedef enum logic [2:0] {IDLE, SEND_OP, SEND_PL, WAIT_RESP, DONE} state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_t          state;
  logic [31:0]     pay_sh;
  logic [2:0]      pl_len, rl_len, pl_cnt, rx_cnt;
  logic [TO_W-1:0] to_cnt;
  logic            tx_last, to_hit;

  function automatic logic [2:0] clamp4(input logic [2:0] v);
    return (v > 3'd4) ? 3'd4 : v;
  endfunction

  assign cmd_ready = (state == IDLE) && rst;
  assign busy      = (state != IDLE);

  // Final byte of the request handed to the PHY this cycle.
  assign tx_last = tx_ready && (((state == SEND_OP) && (pl_len == 3'd0)) ||
                                ((state == SEND_PL) && (pl_cnt == pl_len)));
  assign to_hit  = (state == WAIT_RESP) && !rx_valid && (to_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      pay_sh       <= '0;
      pl_len       <= '0;
      rl_len       <= '0;
      pl_cnt       <= '0;
      rx_cnt       <= '0;
      to_cnt       <= '0;
      tx_valid     <= 1'b0;
      tx_data      <= '0;
      resp_valid   <= 1'b0;
      resp_data    <= '0;
      resp_timeout <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      if (tx_last) begin
        tx_valid <= 1'b0;
        if (rl_len == 3'd0) begin
          state      <= DONE;
          resp_valid <= 1'b1;
        end else begin
          state  <= WAIT_RESP;
          to_cnt <= '0;
        end
      end else begin
        case (state)
          IDLE: if (cmd_valid) begin
            tx_valid     <= 1'b1;
            tx_data      <= cmd_opcode;
            pay_sh       <= cmd_payload;
            pl_len       <= clamp4(cmd_payload_len);
            rl_len       <= clamp4(cmd_resp_len);
            pl_cnt       <= '0;
            rx_cnt       <= '0;
            resp_data    <= '0;
            resp_timeout <= 1'b0;
            state        <= SEND_OP;
          end
          SEND_OP: if (tx_ready) begin
            tx_data <= pay_sh[7:0];
            pay_sh  <= pay_sh >> 8;
            pl_cnt  <= 3'd1;
            state   <= SEND_PL;
          end
          SEND_PL: if (tx_ready) begin
            tx_data <= pay_sh[7:0];
            pay_sh  <= pay_sh >> 8;
            pl_cnt  <= pl_cnt + 3'd1;
          end
          WAIT_RESP: begin
            // A byte arriving on the expiry cycle wins over the timeout.
            if (rx_valid) begin
              resp_data[{rx_cnt[1:0], 3'b000} +: 8] <= rx_data;
              rx_cnt <= rx_cnt + 3'd1;
              to_cnt <= '0;
              if (rx_cnt + 3'd1 == rl_len) begin
                state      <= DONE;
                resp_valid <= 1'b1;
              end
            end else if (to_hit) begin
              resp_timeout <= 1'b1;
              resp_valid   <= 1'b1;
              state        <= DONE;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef TPU_UART_HOST_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_cmds     <= '0;
      stat_timeouts <= '0;
      stat_stray    <= '0;
    end else begin
      if (cmd_valid && cmd_ready && (stat_cmds != 16'hFFFF))
        stat_cmds <= stat_cmds + 16'd1;
      if (to_hit && (stat_timeouts != 8'hFF))
        stat_timeouts <= stat_timeouts + 8'd1;
      if (rx_valid && (state != WAIT_RESP) && (stat_stray != 8'hFF))
        stat_stray <= stat_stray + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tpu_uart_host.sv
// Randomized bench for tpu_uart_host against a transaction-level model of the
// request bytes, response packing and inter-byte timeout rule.
module tb_tpu_uart_host;
  localparam int T = 50;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [7:0]  cmd_opcode;
  logic [31:0] cmd_payload;
  logic [2:0]  cmd_payload_len, cmd_resp_len;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_timeout;
  logic        busy;
`ifdef TPU_UART_HOST_STATS_EN
  logic [15:0] stat_cmds;
  logic [7:0]  stat_timeouts, stat_stray;
`endif

  tpu_uart_host #(.TIMEOUT_CYCLES(T), .TO_W(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_payload(cmd_payload), .cmd_payload_len(cmd_payload_len), .cmd_resp_len(cmd_resp_len),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_timeout(resp_timeout), .busy(busy)
`ifdef TPU_UART_HOST_STATS_EN
    , .stat_cmds(stat_cmds), .stat_timeouts(stat_timeouts), .stat_stray(stat_stray)
`endif
  );

  always #5 clk = ~clk;

  int          errs = 0, checks = 0, accepted = 0;
  int          gap[4];
  logic [31:0] rxw, last_rd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction; rx byte k arrives after gap[k] idle cycles.
  task automatic run_cmd(input logic [7:0] op, input logic [31:0] pl, input int plen,
                         input int rlen, input int mode);
    int pc, rc, m, to, n, w, early, stab;
    logic [7:0]  exp_tx[$];
    logic [31:0] exp_rd;
    logic        prev_stall;
    logic [7:0]  prev_d;
    pc = (plen > 4) ? 4 : plen;
    rc = (rlen > 4) ? 4 : rlen;
    exp_tx = {};
    exp_tx.push_back(op);
    for (int i = 0; i < pc; i++) exp_tx.push_back(pl[8*i +: 8]);
    m = rc; to = 0;
    for (int k = 0; k < rc; k++)
      if (gap[k] >= T) begin m = k; to = 1; break; end
    exp_rd = '0;
    for (int k = 0; k < m; k++) exp_rd[8*k +: 8] = rxw[8*k +: 8];

    w = 0;
    while (!cmd_ready && w < 20) begin step(); w++; end
    chk("cmd_ready", 32'(cmd_ready), 1);
    cmd_valid = 1'b1; cmd_opcode = op; cmd_payload = pl;
    cmd_payload_len = 3'(plen); cmd_resp_len = 3'(rlen);
    step();
    cmd_valid = 1'b0;
    accepted++;
    chk("busy", 32'(busy), 1);

    n = 0; w = 0; stab = 0; prev_stall = 1'b0; prev_d = '0;
    while (n < exp_tx.size() && w < 2000) begin
      if (!tx_valid) stab++;
      if (prev_stall && tx_data !== prev_d) stab++;
      case (mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = 1'($urandom_range(0, 1));
        default: tx_ready = (w >= 5);
      endcase
      if (tx_valid && tx_ready) begin
        chk("tx_byte", 32'(tx_data), 32'(exp_tx[n]));
        n++;
      end
      prev_stall = tx_valid && !tx_ready;
      prev_d = tx_data;
      step();
      w++;
    end
    tx_ready = 1'b0;
    chk("tx_count", n, exp_tx.size());
    chk("tx_stable", stab, 0);

    early = 0;
    if (rc != 0) begin
      for (int k = 0; k < m; k++) begin
        for (int g = 0; g < gap[k]; g++) begin
          early += int'(resp_valid) + int'(tx_valid);
          step();
        end
        early += int'(resp_valid) + int'(tx_valid);
        rx_valid = 1'b1; rx_data = rxw[8*k +: 8];
        step();
        rx_valid = 1'b0;
      end
      if (to != 0)
        for (int g = 0; g < T; g++) begin
          early += int'(resp_valid) + int'(tx_valid);
          step();
        end
    end
    chk("resp_early", early, 0);
    chk("resp_valid", 32'(resp_valid), 1);
    chk("resp_data", resp_data, exp_rd);
    chk("resp_timeout", 32'(resp_timeout), to);
    step();
    chk("pulse_len", 32'(resp_valid), 0);
    chk("idle_busy", 32'(busy), 0);
    chk("resp_hold", resp_data, exp_rd);
    last_rd = exp_rd;
  endtask

  initial begin
    rst = 1'b0; cmd_valid = 1'b0; cmd_opcode = '0; cmd_payload = '0;
    cmd_payload_len = '0; cmd_resp_len = '0; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
    gap = '{0, 0, 0, 0}; rxw = '0; last_rd = '0;
    step(); step();
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_timeout", 32'(resp_timeout), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cmd_ready", 32'(cmd_ready), 0);
    rst = 1'b1;
    step();

    run_cmd(8'h01, 32'h0000BEEF, 2, 0, 0);
    gap = '{45, 45, 45, 45}; rxw = 32'h12345678;
    run_cmd(8'h03, 32'h0, 0, 4, 0);
    gap = '{0, 0, 0, 0}; rxw = 32'hCAFE0001;
    run_cmd(8'h5A, 32'h0, 0, 1, 2);
    gap = '{3, T, 0, 0}; rxw = 32'h000000AA;
    run_cmd(8'h07, 32'h0, 0, 4, 0);
    gap = '{T - 1, T - 1, 0, 0}; rxw = 32'h0000A55A;
    run_cmd(8'h08, 32'h0, 1, 2, 0);
    gap = '{2, 1, 0, 0}; rxw = 32'h00C0FFEE;
    run_cmd(8'h09, 32'h44332211, 7, 7, 0);

    // Stray bytes while idle must not touch the held response.
    for (int i = 0; i < 3; i++) begin
      rx_valid = 1'b1; rx_data = 8'(8'h90 + i);
      step();
      rx_valid = 1'b0;
      step();
    end
    chk("stray_hold", resp_data, last_rd);

    // Reset during payload send.
    cmd_valid = 1'b1; cmd_opcode = 8'h33; cmd_payload = 32'hDDCCBBAA;
    cmd_payload_len = 3'd4; cmd_resp_len = 3'd2; tx_ready = 1'b1;
    step();
    cmd_valid = 1'b0;
    step();
    chk("mid_pl_byte", 32'(tx_data), 32'hAA);
    rst = 1'b0; tx_ready = 1'b0;
    chk("rst_ready_comb", 32'(cmd_ready), 0);
    step();
    chk("abort_tx_valid", 32'(tx_valid), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_resp_data", resp_data, 0);
    rst = 1'b1;
    accepted = 0;
    begin
      int rv = 0;
      for (int i = 0; i < 10; i++) begin
        rv += int'(resp_valid) + int'(tx_valid);
        step();
      end
      chk("abort_quiet", rv, 0);
    end
    gap = '{1, 0, 0, 0}; rxw = 32'h00009977;
    run_cmd(8'h44, 32'h00000066, 1, 2, 1);

    for (int r = 0; r < 30; r++) begin
      for (int k = 0; k < 4; k++) begin
        case ($urandom_range(0, 7))
          0:       gap[k] = T - 1;
          1:       gap[k] = T;
          default: gap[k] = $urandom_range(0, 5);
        endcase
      end
      rxw = $urandom;
      run_cmd(8'($urandom), $urandom, $urandom_range(0, 7), $urandom_range(0, 7), 1);
    end

`ifdef TPU_UART_HOST_STATS_EN
    chk("stat_cmds", 32'(stat_cmds), accepted);
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
